// File: rtl/enc_gray_codec_stream_if.sv
// Stream bundle for the gray codec: input side and output side handshakes.
// slave is the codec's view, master is the producer/consumer view.
interface enc_gray_codec_stream_if #(
   parameter int WIDTH = 10
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_mode;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_mode, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_mode, out_data
   );
endinterface

// File: rtl/enc_gray_codec_stream.sv
// Registered bin<->gray converter with valid/ready stream and 2-entry skid.
// Each word carries its own direction bit; in_ready comes straight from a flop.
module enc_gray_codec_stream #(
   parameter int WIDTH = 10
) (
   input logic clk,
   input logic rst,
   enc_gray_codec_stream_if.slave s
);
   logic [WIDTH-1:0] cvt_data;
   logic             in_fire;
   logic             out_free;

   logic             out_valid_q, out_valid_d;
   logic             out_mode_q, out_mode_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic             skid_mode_q, skid_mode_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             in_ready_q, in_ready_d;

   // gray->bin is an MSB-down prefix XOR; bin->gray is b ^ (b >> 1)
   always_comb begin
      cvt_data = s.in_data ^ (s.in_data >> 1);
      if (s.in_mode) begin
         cvt_data[WIDTH-1] = s.in_data[WIDTH-1];
         for (int i = WIDTH - 2; i >= 0; i--) begin
            cvt_data[i] = cvt_data[i+1] ^ s.in_data[i];
         end
      end
   end

   assign in_fire  = s.in_valid && in_ready_q;
   assign out_free = !out_valid_q || s.out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_mode_d   = out_mode_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_mode_d  = skid_mode_q;
      skid_data_d  = skid_data_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d = 1'b1;
            out_mode_d  = skid_mode_q;
            out_data_d  = skid_data_q;
            if (in_fire) begin
               skid_mode_d = s.in_mode;
               skid_data_d = cvt_data;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_mode_d  = s.in_mode;
            out_data_d  = cvt_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_mode_d  = s.in_mode;
         skid_data_d  = cvt_data;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_mode_q   <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_mode_q  <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_mode_q   <= out_mode_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_mode_q  <= skid_mode_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign s.in_ready  = in_ready_q;
   assign s.out_valid = out_valid_q;
   assign s.out_mode  = out_mode_q;
   assign s.out_data  = out_data_q;
endmodule

// File: tb/tb_enc_gray_codec_stream.sv
// Bench for enc_gray_codec_stream: directed 10-bit, 4-bit round trip,
// and randomised 16-bit handshake traffic against a queue scoreboard.
module tb_enc_gray_codec_stream;
   localparam int NC = 10000;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   always #5 clk = ~clk;

   enc_gray_codec_stream_if #(.WIDTH(10)) ia ();
   enc_gray_codec_stream_if #(.WIDTH(4))  ib ();
   enc_gray_codec_stream_if #(.WIDTH(16)) ic ();

   enc_gray_codec_stream #(.WIDTH(10)) u_a (.clk(clk), .rst(rst_a), .s(ia.slave));
   enc_gray_codec_stream #(.WIDTH(4))  u_b (.clk(clk), .rst(rst_b), .s(ib.slave));
   enc_gray_codec_stream #(.WIDTH(16)) u_c (.clk(clk), .rst(rst_c), .s(ic.slave));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference conversion: gray->bin as XOR of all right shifts
   function automatic logic [63:0] cvt(input logic [63:0] d, input logic m, input int w);
      logic [63:0] r;
      r = '0;
      if (!m) r = d ^ (d >> 1);
      else for (int k = 0; k < w; k++) r = r ^ (d >> k);
      return r;
   endfunction

   logic [63:0] qa[$], qb[$], qc[$];
   logic [3:0]  gotb[$];
   int          c_rcv = 0;

   // scoreboard A with stall-stability check
   initial begin
      logic sa;
      logic [63:0] ha, e;
      sa = 1'b0;
      ha = '0;
      forever begin
         @(negedge clk);
         if (rst_a) begin
            qa.delete();
            sa = 1'b0;
         end else begin
            if (sa) begin
               chk("a_stall_valid", 64'(ia.out_valid), 64'd1);
               chk("a_stall_hold", {ia.out_mode, ia.out_data}, ha);
            end
            sa = ia.out_valid && !ia.out_ready;
            ha = {ia.out_mode, ia.out_data};
            if (ia.out_valid && ia.out_ready) begin
               chk("a_qnonempty", 64'(qa.size() != 0), 64'd1);
               if (qa.size() != 0) chk("a_out", {ia.out_mode, ia.out_data}, qa.pop_front());
            end
            if (ia.in_valid && ia.in_ready) begin
               e = cvt(64'(ia.in_data), ia.in_mode, 10);
               qa.push_back({ia.in_mode, e[9:0]});
            end
         end
      end
   end

   // scoreboard B, also records outputs for the round trip
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst_b) qb.delete();
         else begin
            if (ib.out_valid && ib.out_ready) begin
               chk("b_qnonempty", 64'(qb.size() != 0), 64'd1);
               if (qb.size() != 0) chk("b_out", {ib.out_mode, ib.out_data}, qb.pop_front());
               gotb.push_back(ib.out_data);
            end
            if (ib.in_valid && ib.in_ready) begin
               e = cvt(64'(ib.in_data), ib.in_mode, 4);
               qb.push_back({ib.in_mode, e[3:0]});
            end
         end
      end
   end

   // scoreboard C with stall-stability check
   initial begin
      logic sc;
      logic [63:0] hc, e;
      sc = 1'b0;
      hc = '0;
      forever begin
         @(negedge clk);
         if (rst_c) begin
            qc.delete();
            sc = 1'b0;
         end else begin
            if (sc) begin
               chk("c_stall_valid", 64'(ic.out_valid), 64'd1);
               chk("c_stall_hold", {ic.out_mode, ic.out_data}, hc);
            end
            sc = ic.out_valid && !ic.out_ready;
            hc = {ic.out_mode, ic.out_data};
            if (ic.out_valid && ic.out_ready) begin
               chk("c_qnonempty", 64'(qc.size() != 0), 64'd1);
               if (qc.size() != 0) chk("c_out", {ic.out_mode, ic.out_data}, qc.pop_front());
               c_rcv++;
            end
            if (ic.in_valid && ic.in_ready) begin
               e = cvt(64'(ic.in_data), ic.in_mode, 16);
               qc.push_back({ic.in_mode, e[15:0]});
            end
         end
      end
   end

   // one clock of A: report whether the input is taken at this edge
   task automatic a_step(output bit acc);
      @(negedge clk);
      acc = ia.in_valid && ia.in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic a_xfer(input logic m, input logic [9:0] d, input logic [9:0] exp);
      bit acc;
      ia.in_valid = 1'b1;
      ia.in_mode  = m;
      ia.in_data  = d;
      a_step(acc);
      chk("a_accept", 64'(acc), 64'd1);
      ia.in_valid = 1'b0;
      @(negedge clk);
      chk("a_lat_valid", 64'(ia.out_valid), 64'd1);
      chk("a_lat_data", 64'(ia.out_data), 64'(exp));
      chk("a_lat_mode", 64'(ia.out_mode), 64'(m));
      @(posedge clk);
      #1;
   endtask

   task automatic b_put(input logic m, input logic [3:0] d);
      bit acc;
      int guard;
      ib.in_valid = 1'b1;
      ib.in_mode  = m;
      ib.in_data  = d;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = ib.in_valid && ib.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) chk("b_accept_timeout", 64'(acc), 64'd1);
      ib.in_valid = 1'b0;
   endtask

   bit c_go = 1'b0;
   initial begin
      wait (c_go);
      forever begin
         @(posedge clk);
         #1;
         ic.out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      bit acc;
      int nxt, sent, guard;
      logic [9:0] bp_exp [4];
      bp_exp = '{10'h001, 10'h003, 10'h002, 10'h006};

      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      ia.in_valid = 1'b0; ia.in_mode = 1'b0; ia.in_data = '0; ia.out_ready = 1'b0;
      ib.in_valid = 1'b0; ib.in_mode = 1'b0; ib.in_data = '0; ib.out_ready = 1'b0;
      ic.in_valid = 1'b0; ic.in_mode = 1'b0; ic.in_data = '0; ic.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
      chk("rst_out_mode", 64'(ia.out_mode), 64'd0);
      chk("rst_out_data", 64'(ia.out_data), 64'd0);
      chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;

      // directed conversions with one-cycle latency
      ia.out_ready = 1'b1;
      a_xfer(1'b0, 10'h2AA, 10'h3FF);
      a_xfer(1'b0, 10'h200, 10'h300);
      a_xfer(1'b1, 10'h3FF, 10'h2AA);
      a_xfer(1'b1, 10'h300, 10'h200);

      // back-to-back mixed modes
      ia.in_valid = 1'b1; ia.in_mode = 1'b0; ia.in_data = 10'h2AA;
      @(posedge clk);
      #1;
      ia.in_mode = 1'b1; ia.in_data = 10'h3FF;
      @(negedge clk);
      chk("b2b_first", {ia.out_valid, ia.out_mode, ia.out_data}, {1'b1, 1'b0, 10'h3FF});
      @(posedge clk);
      #1;
      ia.in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_second", {ia.out_valid, ia.out_mode, ia.out_data}, {1'b1, 1'b1, 10'h2AA});
      @(posedge clk);
      #1;

      // backpressure: words 1..4 with out_ready low for 4 cycles
      ia.out_ready = 1'b0;
      ia.in_mode = 1'b0;
      ia.in_valid = 1'b1;
      nxt = 1;
      ia.in_data = 10'd1;
      repeat (4) begin
         a_step(acc);
         if (acc) begin
            nxt++;
            ia.in_data = 10'(nxt);
         end
      end
      chk("bp_accepted", 64'(nxt - 1), 64'd2);
      @(negedge clk);
      chk("bp_in_ready", 64'(ia.in_ready), 64'd0);
      chk("bp_hold_data", 64'(ia.out_data), 64'h001);
      @(posedge clk);
      #1;
      ia.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_seq_valid", 64'(ia.out_valid), 64'd1);
         chk("bp_seq_data", 64'(ia.out_data), 64'(bp_exp[k]));
         acc = ia.in_valid && ia.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            if (nxt == 4) ia.in_valid = 1'b0;
            else begin
               nxt++;
               ia.in_data = 10'(nxt);
            end
         end
      end
      repeat (2) @(posedge clk);
      #1;

      // reset with output and skid both full
      ia.out_ready = 1'b0;
      ia.in_valid = 1'b1; ia.in_mode = 1'b0; ia.in_data = 10'h011;
      a_step(acc);
      ia.in_data = 10'h022;
      a_step(acc);
      ia.in_valid = 1'b0;
      @(negedge clk);
      chk("full_in_ready", 64'(ia.in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(ia.out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(ia.in_ready), 64'd1);
      @(posedge clk);
      #1;
      ia.out_ready = 1'b1;
      a_xfer(1'b0, 10'h005, 10'h007);
      repeat (4) @(posedge clk);
      #1;
      chk("a_q_empty", 64'(qa.size()), 64'd0);

      // 4-bit exhaustive round trip
      ib.out_ready = 1'b1;
      for (int v = 0; v < 16; v++) b_put(1'b0, 4'(v));
      repeat (3) @(posedge clk);
      #1;
      chk("rt_gray_count", 64'(gotb.size()), 64'd16);
      if (gotb.size() == 16) begin
         for (int v = 0; v < 16; v++) b_put(1'b1, gotb[v]);
         repeat (3) @(posedge clk);
         #1;
         chk("rt_back_count", 64'(gotb.size()), 64'd32);
         if (gotb.size() == 32) begin
            for (int v = 0; v < 16; v++) chk("rt_back", 64'(gotb[16+v]), 64'(v));
            for (int v = 0; v < 15; v++) chk("gray_adj", 64'($countones(gotb[v] ^ gotb[v+1])), 64'd1);
         end
      end

      // random traffic on the 16-bit instance
      c_go = 1'b1;
      sent = 0;
      while (sent < NC) begin
         if (!ic.in_valid && $urandom_range(0, 3) != 0) begin
            ic.in_valid = 1'b1;
            ic.in_mode  = 1'($urandom);
            ic.in_data  = 16'($urandom);
         end
         @(negedge clk);
         acc = ic.in_valid && ic.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            ic.in_valid = 1'b0;
         end
      end
      ic.in_valid = 1'b0;
      guard = 0;
      while (c_rcv < NC && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      #1;
      chk("c_drain", 64'(c_rcv), 64'(NC));
      chk("c_q_empty", 64'(qc.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
